dsp_fb_calc: RTL
================

DSP_FB_CALC -- requirements
Module: dsp_fb_calc

Interface
REQ-001 SHALL have parameter NCH, default 2, number of independent charge x signal channels (1..8).
REQ-002 SHALL have parameter CW, default 21, signed charge width per channel.
REQ-003 SHALL have parameter SW, default 17, signed signal width per channel.
REQ-004 SHALL have parameter OW, default 15, signed output width per channel.
REQ-005 SHALL have parameter FRAC, default 12, LSBs discarded from the product (LUT scale removal).
REQ-006 SHALL have parameter JW, default 8, sample-counter width.
REQ-007 SHALL have ports: clk  in  1  sole clock, rising edge; one clock; reset is asynchronous and active-low.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 charge_in  in  NCH*CW  packed signed charges, channel 0 in LSBs.
REQ-010 signal_in  in  NCH*SW  packed signed signals, channel 0 in LSBs.
REQ-011 store_strb  in  1  acquisition window; low forces sequencer idle.
REQ-012 bunch_strb  in  1  bunch arrival, starts sample count.
REQ-013 fb_en  in  1  feedback enable, gates fb_cond and dac_clk.
REQ-014 sat_en  in  1  1 = saturate pout on overflow, 0 = wrap (truncate).
REQ-015 cond_start  in  JW  count value opening the fb_cond window.
REQ-016 dac_start  in  JW  count value opening the dac_clk window.
REQ-017 pout  out  NCH*OW  packed signed scaled products.
REQ-018 oflow  out  NCH  per-channel overflow flag, aligned with pout.
REQ-019 fb_cond  out  1  feedback-condition strobe.
REQ-020 dac_clk  out  1  DAC update strobe.

Function
REQ-021 Datapath SHALL be 3 stages per channel: S1 registers charge and signal; S2 registers full signed product (CW+SW bits); S3 registers pout and oflow; latency 3 clocks, throughput 1/clock.
REQ-022 Overflow SHALL be set when product bits [CW+SW-1 : FRAC+OW-1] are not all equal.
REQ-023 Without overflow, or with sat_en=0, pout SHALL equal product bits [FRAC+OW-1 : FRAC] (truncation, no rounding).
REQ-024 With sat_en=1 and overflow, pout SHALL be +(2^(OW-1)-1) for non-negative product, -2^(OW-1) for negative.
REQ-025 oflow SHALL assert regardless of sat_en.
REQ-026 Channels SHALL be fully independent; no cross-channel arithmetic.
REQ-027 Sequencer SHALL have states IDLE and COUNT with counter j (JW bits); j=0 in IDLE.
REQ-028 IDLE->COUNT on edge where store_strb=1 and bunch_strb=1; j loads 1; j increments by 1 each following clock.
REQ-029 bunch_strb in COUNT SHALL be ignored (no restart).
REQ-030 j SHALL saturate at 2^JW-1 and not wrap.
REQ-031 COUNT->IDLE, j=0, on edge where j==dac_start+1 (second dac pulse latched).
REQ-032 store_strb=0 SHALL force IDLE, j=0 on next edge, overriding all other transitions.
REQ-033 fb_cond SHALL be registered, high exactly on the two clocks following edges where j==cond_start and j==cond_start+1, only if fb_en=1.
REQ-034 dac_clk SHALL be registered, high on clocks following edges where j==dac_start or j==dac_start+1, or during a clear pulse, only if fb_en=1.
REQ-035 A clear pulse SHALL be generated on store_strb falling edge (registered 1->0): dac_clk high for the 2 clocks following detection.
REQ-036 fb_en=0 SHALL force fb_cond=0 and dac_clk=0 on next edge; sequencer and datapath continue running.
REQ-037 cond_start, dac_start SHALL be sampled live; legal use requires 1 <= cond_start < dac_start <= 2^JW-3; outside this, window pulses may be absent, no lock-up beyond store_strb low.

Reset
REQ-038 rst_n low SHALL asynchronously clear all pipeline registers, pout, oflow, fb_cond, dac_clk, j, clear-pulse logic and select IDLE.
REQ-039 Reset deassertion SHALL not generate a clear pulse even if store_strb is high.
REQ-040 Reset mid-COUNT SHALL abort the sequence; a new bunch_strb is required after release.

Verification
REQ-041 NCH=2, ch0 charge=4096, signal=100 -> pout ch0=100, oflow=0, exactly 3 clocks later.
REQ-042 charge=2^20-1, signal=2^16-1, sat_en=1 -> pout=16383, oflow=1; sat_en=0 -> truncated bits, oflow=1; negative signal -> -16384 saturated.
REQ-043 fb_en=1, store_strb=1, cond_start=17, dac_start=20, bunch_strb at edge 0 -> fb_cond high after edges 17,18; dac_clk high after edges 20,21; IDLE after edge 21.
REQ-044 store_strb dropped at j=10 -> IDLE next edge, no fb_cond, 2-clock dac_clk clear pulse.
REQ-045 Second bunch_strb at j=5 -> ignored, windows unchanged; fb_en=0 throughout -> no strobes.
REQ-046 rst_n low at j=12 -> all outputs 0 asynchronously; after release no strobes until new bunch_strb.

Source files
------------

// File: rtl/dsp_fb_calc.sv
// Feedback calculator: per-channel scaled charge x signal product with
// saturate/wrap output, plus a bunch-triggered sequencer that times the
// feedback-condition and DAC-update strobes.

// One channel of the 3-stage multiply/scale pipeline.
module dsp_fb_lane #(
  parameter int CW   = 21,
  parameter int SW   = 17,
  parameter int OW   = 15,
  parameter int FRAC = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CW-1:0] charge_i,
  input  logic [SW-1:0] signal_i,
  input  logic          sat_en_i,
  output logic [OW-1:0] pout_o,
  output logic          oflow_o
);
  localparam int PW = CW + SW;
  localparam int HB = FRAC + OW - 1;   // top bit kept in the output (sign bit)

  logic signed [CW-1:0] chg_q;
  logic signed [SW-1:0] sig_q;
  logic signed [PW-1:0] prod_q, prod_d;
  logic        [OW-1:0] pout_q, pout_d;
  logic                 oflow_q, oflow_d;
  logic      [PW-1-HB:0] hi;

  // Full-width signed product; both operands sign-extended before multiply.
  always_comb prod_d = PW'(chg_q) * PW'(sig_q);

  // Overflow when the discarded high bits are not a pure sign extension.
  always_comb begin
    hi      = prod_q[PW-1:HB];
    oflow_d = !((&hi) || !(|hi));
    pout_d  = prod_q[HB:FRAC];
    if (oflow_d && sat_en_i)
      pout_d = prod_q[PW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
  end

  // S1 input capture, S2 product, S3 scaled result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chg_q   <= '0;
      sig_q   <= '0;
      prod_q  <= '0;
      pout_q  <= '0;
      oflow_q <= 1'b0;
    end else begin
      chg_q   <= charge_i;
      sig_q   <= signal_i;
      prod_q  <= prod_d;
      pout_q  <= pout_d;
      oflow_q <= oflow_d;
    end
  end

  assign pout_o  = pout_q;
  assign oflow_o = oflow_q;
endmodule

module dsp_fb_calc #(
  parameter int NCH  = 2,
  parameter int CW   = 21,
  parameter int SW   = 17,
  parameter int OW   = 15,
  parameter int FRAC = 12,
  parameter int JW   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH*CW-1:0] charge_in,
  input  logic [NCH*SW-1:0] signal_in,
  input  logic              store_strb,
  input  logic              bunch_strb,
  input  logic              fb_en,
  input  logic              sat_en,
  input  logic [JW-1:0]     cond_start,
  input  logic [JW-1:0]     dac_start,
  output logic [NCH*OW-1:0] pout,
  output logic [NCH-1:0]    oflow,
  output logic              fb_cond,
  output logic              dac_clk
);
  typedef enum logic {IDLE, COUNT} st_t;

  st_t           st_q, st_d;
  logic [JW-1:0] j_q, j_d;
  logic          store_q, clr_q, fall;
  logic          fb_cond_q, fb_cond_d, dac_clk_q, dac_clk_d;
  logic [JW-1:0] cond_p1, dac_p1;
  logic          cond_hit, dac_hit;

  genvar g;
  generate
    for (g = 0; g < NCH; g++) begin : g_lane
      dsp_fb_lane #(.CW(CW), .SW(SW), .OW(OW), .FRAC(FRAC)) u_lane (
        .clk      (clk),
        .rst_n    (rst_n),
        .charge_i (charge_in[g*CW +: CW]),
        .signal_i (signal_in[g*SW +: SW]),
        .sat_en_i (sat_en),
        .pout_o   (pout[g*OW +: OW]),
        .oflow_o  (oflow[g])
      );
    end
  endgenerate

  assign cond_p1 = cond_start + JW'(1);
  assign dac_p1  = dac_start + JW'(1);
  assign fall    = store_q & ~store_strb;

  // Sequencer next state: store low wins, then start/stop/count.
  always_comb begin
    st_d = st_q;
    j_d  = j_q;
    if (!store_strb) begin
      st_d = IDLE;
      j_d  = '0;
    end else begin
      case (st_q)
        IDLE: if (bunch_strb) begin
          st_d = COUNT;
          j_d  = JW'(1);
        end
        COUNT: begin
          if (j_q == dac_p1) begin
            st_d = IDLE;
            j_d  = '0;
          end else if (j_q != {JW{1'b1}}) begin
            j_d = j_q + JW'(1);
          end
        end
        default: begin
          st_d = IDLE;
          j_d  = '0;
        end
      endcase
    end
  end

  // Strobe decode: two-clock windows from the live start values, plus clear pulse.
  always_comb begin
    cond_hit  = (st_q == COUNT) && ((j_q == cond_start) || (j_q == cond_p1));
    dac_hit   = (st_q == COUNT) && ((j_q == dac_start) || (j_q == dac_p1));
    fb_cond_d = fb_en & cond_hit;
    dac_clk_d = fb_en & (dac_hit | fall | clr_q);
  end

  // Sequencer, store-edge detector and registered strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= IDLE;
      j_q       <= '0;
      store_q   <= 1'b0;
      clr_q     <= 1'b0;
      fb_cond_q <= 1'b0;
      dac_clk_q <= 1'b0;
    end else begin
      st_q      <= st_d;
      j_q       <= j_d;
      store_q   <= store_strb;
      clr_q     <= fall;
      fb_cond_q <= fb_cond_d;
      dac_clk_q <= dac_clk_d;
    end
  end

  assign fb_cond = fb_cond_q;
  assign dac_clk = dac_clk_q;
endmodule
